// File: rtl/numlock_access_ctrl_if.sv
// Signal bundle between the pushbuttons, the number-lock FSM and the access controller.
// The controller takes the slave view; the button/lock side takes the master view.
interface numlock_access_ctrl_if;
    logic       btn_u;
    logic       btn_z;
    logic [3:0] lock_q;
    logic       lock_unlock;
    logic       lock_u;
    logic       lock_z;
    logic       lock_rst;
    logic       door_open;
    logic       locked_out;
    logic [2:0] fail_count;
    logic [2:0] ctrl_state;

    modport master (
        output btn_u, btn_z, lock_q, lock_unlock,
        input  lock_u, lock_z, lock_rst, door_open, locked_out, fail_count, ctrl_state
    );

    modport slave (
        input  btn_u, btn_z, lock_q, lock_unlock,
        output lock_u, lock_z, lock_rst, door_open, locked_out, fail_count, ctrl_state
    );
endinterface

// File: rtl/numlock_access_ctrl.sv
// Supervisory controller for the number lock: gates the U/Z buttons into the lock,
// counts consecutive failed entries and enforces a timed lockout after too many.
module numlock_access_ctrl #(
    parameter logic [3:0]  INITIAL_CODE = 4'b0000,
    parameter logic [3:0]  BAD_CODE     = 4'b1010,
    parameter int unsigned MAX_FAILS    = 3,
    parameter int unsigned ATTEMPT_TO   = 1000,
    parameter int unsigned LOCKOUT_CYC  = 5000
) (
    input logic                  clk,
    input logic                  rst,
    numlock_access_ctrl_if.slave bus
);

    localparam int unsigned AtW = (ATTEMPT_TO > 1) ? $clog2(ATTEMPT_TO) : 1;
    localparam int unsigned LoW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    localparam logic [AtW-1:0] AtLast  = AtW'(ATTEMPT_TO - 1);
    localparam logic [LoW-1:0] LoLast  = LoW'(LOCKOUT_CYC - 1);
    localparam logic [2:0]     FailMax = 3'(MAX_FAILS);

    typedef enum logic [2:0] {
        StReady   = 3'd0,
        StAttempt = 3'd1,
        StFailed  = 3'd2,
        StLockout = 3'd3,
        StOpen    = 3'd4,
        StWaitRel = 3'd5
    } state_e;

    state_e         state_q, state_d;
    logic [AtW-1:0] at_cnt_q, at_cnt_d;
    logic [LoW-1:0] lo_cnt_q, lo_cnt_d;
    logic [2:0]     fail_q, fail_d;
    logic [1:0]     btn_prev_q;

    logic       activity;
    logic       lock_idle;
    logic [2:0] fail_inc;
    logic       mask;

    assign activity  = {bus.btn_u, bus.btn_z} != btn_prev_q;
    assign lock_idle = (bus.lock_q == INITIAL_CODE);
    // Saturating increment so the count can never pass the lockout threshold
    assign fail_inc  = (fail_q >= FailMax) ? FailMax : fail_q + 3'd1;

    // State, timers, failure count and previous-button register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StReady;
            at_cnt_q   <= '0;
            lo_cnt_q   <= '0;
            fail_q     <= '0;
            btn_prev_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            at_cnt_q   <= at_cnt_d;
            lo_cnt_q   <= lo_cnt_d;
            fail_q     <= fail_d;
            btn_prev_q <= {bus.btn_u, bus.btn_z};
        end
    end

    // Next-state, timer and failure-count logic
    always_comb begin
        state_d  = state_q;
        at_cnt_d = at_cnt_q;
        lo_cnt_d = lo_cnt_q;
        fail_d   = fail_q;
        case (state_q)
            StReady: begin
                if (!lock_idle) begin
                    state_d  = StAttempt;
                    at_cnt_d = '0;
                end
            end
            StAttempt: begin
                // Unlock beats a simultaneous BAD/timeout; BAD and timeout count once
                if (bus.lock_unlock) begin
                    state_d = StOpen;
                    fail_d  = '0;
                end else if (bus.lock_q == BAD_CODE || at_cnt_q == AtLast) begin
                    state_d = StFailed;
                end else if (lock_idle) begin
                    state_d = StReady;
                end else if (activity) begin
                    at_cnt_d = '0;
                end else if (at_cnt_q != AtLast) begin
                    at_cnt_d = at_cnt_q + AtW'(1);
                end
            end
            StFailed: begin
                fail_d = fail_inc;
                if (fail_inc == FailMax) begin
                    state_d  = StLockout;
                    lo_cnt_d = '0;
                end else begin
                    state_d = StWaitRel;
                end
            end
            StLockout: begin
                if (lo_cnt_q == LoLast) begin
                    state_d = StWaitRel;
                    fail_d  = '0;
                end else begin
                    lo_cnt_d = lo_cnt_q + LoW'(1);
                end
            end
            StOpen: begin
                if (!bus.lock_unlock) begin
                    state_d = StWaitRel;
                end
            end
            StWaitRel: begin
                if (!bus.btn_u && !bus.btn_z && lock_idle) begin
                    state_d = StReady;
                end
            end
            default: state_d = StReady;
        endcase
    end

    // Buttons are blocked whenever the lock is being reset, is open or awaits release
    assign mask = (state_q == StFailed) || (state_q == StLockout) ||
                  (state_q == StOpen)   || (state_q == StWaitRel);

    assign bus.lock_u     = bus.btn_u & ~mask;
    assign bus.lock_z     = bus.btn_z & ~mask;
    assign bus.lock_rst   = (state_q == StFailed) || (state_q == StLockout);
    assign bus.door_open  = (state_q == StOpen);
    assign bus.locked_out = (state_q == StLockout);
    assign bus.fail_count = fail_q;
    assign bus.ctrl_state = state_q;

endmodule

// File: tb/tb_numlock_access_ctrl.sv
// Self-checking bench for numlock_access_ctrl: a behavioural number lock (code 1-0-1-1,
// U = 1, Z = 0) closes the loop, and a cycle-level reference model checks every output.
module tb_numlock_access_ctrl;

    localparam int TO   = 20;
    localparam int LC   = 50;
    localparam int MAXF = 3;
    localparam logic [3:0] BAD = 4'hA;
    localparam int OPEN_HOLD = 8;

    localparam int M_READY = 0, M_ATTEMPT = 1, M_FAILED = 2;
    localparam int M_LOCKOUT = 3, M_OPEN = 4, M_WAITREL = 5;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    numlock_access_ctrl_if bus ();

    numlock_access_ctrl #(
        .INITIAL_CODE (4'h0),
        .BAD_CODE     (BAD),
        .MAX_FAILS    (MAXF),
        .ATTEMPT_TO   (TO),
        .LOCKOUT_CYC  (LC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural number lock ----------------
    int         code_digit [4] = '{1, 0, 1, 1};
    int         lk_step;
    int         lk_open_cnt;
    logic [1:0] lk_prev;

    always @(posedge clk or posedge rst) begin : lock_model
        logic rise_u, rise_z, dig;
        if (rst) begin
            bus.lock_q      <= 4'h0;
            bus.lock_unlock <= 1'b0;
            lk_step         <= 0;
            lk_open_cnt     <= 0;
            lk_prev         <= 2'b00;
        end else begin
            rise_u = bus.lock_u & ~lk_prev[1];
            rise_z = bus.lock_z & ~lk_prev[0];
            lk_prev <= {bus.lock_u, bus.lock_z};
            if (bus.lock_rst) begin
                bus.lock_q      <= 4'h0;
                bus.lock_unlock <= 1'b0;
                lk_step         <= 0;
            end else if (bus.lock_unlock) begin
                if (lk_open_cnt == OPEN_HOLD - 1) begin
                    bus.lock_q      <= 4'h0;
                    bus.lock_unlock <= 1'b0;
                    lk_step         <= 0;
                end else begin
                    lk_open_cnt <= lk_open_cnt + 1;
                end
            end else if (bus.lock_q != BAD) begin
                if (rise_u && rise_z) begin
                    bus.lock_q <= BAD;
                end else if (rise_u || rise_z) begin
                    dig = rise_u;
                    if (int'(dig) != code_digit[lk_step]) begin
                        bus.lock_q <= BAD;
                    end else if (lk_step == 3) begin
                        bus.lock_q      <= 4'hF;
                        bus.lock_unlock <= 1'b1;
                        lk_open_cnt     <= 0;
                    end else begin
                        bus.lock_q <= 4'(lk_step + 1);
                        lk_step    <= lk_step + 1;
                    end
                end
            end
        end
    end

    // ---------------- reference model of the controller ----------------
    // Idle time is tracked as cycles since entry/activity, lockout as cycles remaining.
    int         m_mode, m_idle, m_left, m_fails;
    logic [1:0] m_prev;

    always @(posedge clk or posedge rst) begin : ref_model
        int mode_n, idle_n, left_n, fails_n;
        logic [1:0] btns;
        if (rst) begin
            m_mode  <= M_READY;
            m_idle  <= 0;
            m_left  <= 0;
            m_fails <= 0;
            m_prev  <= 2'b00;
        end else begin
            btns    = {bus.btn_u, bus.btn_z};
            mode_n  = m_mode;
            idle_n  = m_idle;
            left_n  = m_left;
            fails_n = m_fails;
            if (m_mode == M_READY) begin
                if (bus.lock_q != 4'h0) begin
                    mode_n = M_ATTEMPT;
                    idle_n = 0;
                end
            end else if (m_mode == M_ATTEMPT) begin
                if (bus.lock_unlock) begin
                    mode_n  = M_OPEN;
                    fails_n = 0;
                end else if (bus.lock_q == BAD || m_idle >= TO - 1) begin
                    mode_n = M_FAILED;
                end else if (bus.lock_q == 4'h0) begin
                    mode_n = M_READY;
                end else if (btns != m_prev) begin
                    idle_n = 0;
                end else begin
                    idle_n = m_idle + 1;
                end
            end else if (m_mode == M_FAILED) begin
                fails_n = (m_fails + 1 > MAXF) ? MAXF : m_fails + 1;
                if (fails_n == MAXF) begin
                    mode_n = M_LOCKOUT;
                    left_n = LC;
                end else begin
                    mode_n = M_WAITREL;
                end
            end else if (m_mode == M_LOCKOUT) begin
                left_n = m_left - 1;
                if (left_n == 0) begin
                    mode_n  = M_WAITREL;
                    fails_n = 0;
                end
            end else if (m_mode == M_OPEN) begin
                if (!bus.lock_unlock) mode_n = M_WAITREL;
            end else begin
                if (btns == 2'b00 && bus.lock_q == 4'h0) mode_n = M_READY;
            end
            m_mode  <= mode_n;
            m_idle  <= idle_n;
            m_left  <= left_n;
            m_fails <= fails_n;
            m_prev  <= btns;
        end
    end

    // Per-cycle comparison of every output against the model, plus lockout length
    int lo_run = 0;
    always @(negedge clk) begin
        logic mask;
        mask = (m_mode >= M_FAILED) && (m_mode <= M_WAITREL);
        check_eq("lock_u", bus.lock_u, bus.btn_u & ~mask);
        check_eq("lock_z", bus.lock_z, bus.btn_z & ~mask);
        check_eq("lock_rst", bus.lock_rst, (m_mode == M_FAILED) || (m_mode == M_LOCKOUT));
        check_eq("door_open", bus.door_open, m_mode == M_OPEN);
        check_eq("locked_out", bus.locked_out, m_mode == M_LOCKOUT);
        check_eq("fail_count", bus.fail_count, m_fails);
        check_eq("ctrl_state", bus.ctrl_state, m_mode);
        if (rst) begin
            lo_run = 0;
        end else if (bus.locked_out) begin
            lo_run++;
        end else if (lo_run != 0) begin
            check_eq("lockout_len", lo_run, LC);
            lo_run = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic u, input logic z, input int hold, input int gap);
        bus.btn_u = u;
        bus.btn_z = z;
        repeat (hold) tick();
        bus.btn_u = 1'b0;
        bus.btn_z = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic enter_code(input logic [3:0] bits, input int n, input int hold, input int gap);
        for (int k = 0; k < n; k++) press(bits[3-k], ~bits[3-k], hold, gap);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        repeat (3) tick();
        while (bus.ctrl_state != 3'd0 && n < 400) begin
            tick();
            n++;
        end
        check_eq(tag, bus.ctrl_state, 0);
    endtask

    task automatic wait_lockout(input string tag);
        int n;
        n = 0;
        while (!bus.locked_out && n < 100) begin
            tick();
            n++;
        end
        check_eq(tag, bus.locked_out, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst             = 1'b1;
        bus.btn_u       = 1'b0;
        bus.btn_z       = 1'b0;
        repeat (2) tick();
        // Reset values and pass-through during reset
        check_eq("rst_state", bus.ctrl_state, 0);
        check_eq("rst_fail", bus.fail_count, 0);
        check_eq("rst_lock_rst", bus.lock_rst, 0);
        bus.btn_u = 1'b1;
        #1;
        check_eq("rst_passthru", bus.lock_u, 1);
        bus.btn_u = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // One wrong entry
        press(1'b0, 1'b1, 3, 3);
        wait_ready("ready_after_bad");
        check_eq("fail_one", bus.fail_count, 1);

        // Two more wrong entries -> lockout; hold U through it
        press(1'b0, 1'b1, 3, 3);
        wait_ready("ready_after_bad2");
        check_eq("fail_two", bus.fail_count, 2);
        press(1'b0, 1'b1, 3, 3);
        bus.btn_u = 1'b1;
        wait_lockout("lockout_enter");
        repeat (30) tick();
        check_eq("masked_u", bus.lock_u, 0);
        bus.btn_u = 1'b0;
        wait_ready("ready_after_lockout");
        check_eq("fail_cleared", bus.fail_count, 0);

        // Two failures then the correct code
        press(1'b0, 1'b1, 2, 3);
        wait_ready("ready_f1");
        press(1'b1, 1'b1, 2, 3);
        wait_ready("ready_f2");
        check_eq("fail_pre_open", bus.fail_count, 2);
        enter_code(4'b1011, 3, 2, 2);
        bus.btn_u = 1'b1;
        for (int n = 0; n < 10 && !bus.door_open; n++) tick();
        check_eq("door_open_seen", bus.door_open, 1);
        check_eq("fail_on_open", bus.fail_count, 0);
        bus.btn_u = 1'b0;
        wait_ready("ready_after_open");
        press(1'b0, 1'b1, 2, 3);
        wait_ready("ready_f3");
        check_eq("fail_after_open", bus.fail_count, 1);
        check_eq("no_lockout", bus.locked_out, 0);

        // Reach lockout again and reset 25 cycles in
        press(1'b0, 1'b1, 2, 3);
        wait_ready("ready_f4");
        press(1'b0, 1'b1, 2, 3);
        wait_lockout("lockout_enter2");
        repeat (25) tick();
        rst = 1'b1;
        #1;
        check_eq("rst_mid_lockout", bus.locked_out, 0);
        check_eq("rst_mid_fail", bus.fail_count, 0);
        repeat (2) tick();
        rst = 1'b0;
        bus.btn_u = 1'b1;
        #1;
        check_eq("passthru_after_rst", bus.lock_u, 1);
        tick();
        // First digit then idle: attempt times out
        bus.btn_u = 1'b0;
        repeat (TO + 5) tick();
        wait_ready("ready_after_timeout");
        check_eq("fail_timeout", bus.fail_count, 1);

        // Slow entry: button activity every 10 cycles keeps the attempt alive
        enter_code(4'b1011, 3, 10, 10);
        check_eq("attempt_alive", bus.ctrl_state, M_ATTEMPT);
        press(1'b1, 1'b0, 10, 2);
        wait_ready("ready_after_slow");
        check_eq("fail_after_slow", bus.fail_count, 0);

        // Randomized sessions
        for (int s = 0; s < 40; s++) begin
            logic [3:0] bits;
            int kind;
            kind = $urandom_range(0, 4);
            case (kind)
                0: enter_code(4'b1011, 4, $urandom_range(1, 6), $urandom_range(1, 12));
                1: begin
                    bits = 4'($urandom);
                    if (bits == 4'b1011) bits = 4'b1010;
                    enter_code(bits, 4, $urandom_range(1, 6), $urandom_range(1, 25));
                    if ($urandom_range(0, 1) == 1) begin
                        bus.btn_u = 1'b1;
                        repeat ($urandom_range(1, 60)) tick();
                        bus.btn_u = 1'b0;
                    end
                end
                2: begin
                    enter_code(4'b1011, $urandom_range(1, 3), $urandom_range(1, 6),
                               $urandom_range(1, 8));
                    repeat (TO + 5) tick();
                end
                3: enter_code(4'b1011, 4, 10, 10);
                default: begin
                    for (int k = 0; k < 6; k++) begin
                        press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              $urandom_range(1, 6), $urandom_range(1, 25));
                    end
                end
            endcase
            wait_ready("session_ready");
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/numlock_access_ctrl.md
# numlock_access_ctrl

Supervisory controller placed between the U/Z pushbuttons and the number-lock state machine. It gates the buttons into the lock and counts consecutive failed code entries. After too many failures or an abandoned entry it resets the lock and enforces a timed lockout. It also reports open/lockout status to the board LEDs.

## Interface

Parameters:
- INITIAL_CODE, 4'b0000: lock state code for idle/initial.
- BAD_CODE, 4'b1010: lock state code for the BAD state.
- MAX_FAILS, 3: consecutive failures that trigger lockout (range 1..7).
- ATTEMPT_TO, 1000: idle cycles allowed inside an attempt before it counts as failed.
- LOCKOUT_CYC, 5000: lockout duration in cycles.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-high reset.
- btn_u, in, 1: U button, already synchronized, level.
- btn_z, in, 1: Z button, already synchronized, level.
- lock_q, in, 4: current lock state, {q3,q2,q1,q0}.
- lock_unlock, in, 1: lock unlock output.
- lock_u, out, 1: gated U to the lock.
- lock_z, out, 1: gated Z to the lock.
- lock_rst, out, 1: synchronous reset request to the lock.
- door_open, out, 1: high while the lock is open.
- locked_out, out, 1: high during lockout.
- fail_count, out, 3: consecutive failure count.
- ctrl_state, out, 3: current controller state, for debug.

## Operation

- State encoding: READY=0, ATTEMPT=1, FAILED=2, LOCKOUT=3, OPEN=4, WAIT_REL=5. Any other value goes to READY.
- mask = state ∈ {FAILED, LOCKOUT, OPEN, WAIT_REL}.
  - lock_u = btn_u & ~mask; lock_z = btn_z & ~mask (combinational, zero latency).
- lock_rst = state ∈ {FAILED, LOCKOUT}, decoded from the state register.
- door_open = (state==OPEN); locked_out = (state==LOCKOUT).
- btn_prev register holds the previous {btn_u,btn_z}. Activity = {btn_u,btn_z} != btn_prev.

Transitions:
- READY: if lock_q != INITIAL_CODE, go to ATTEMPT and clear the attempt timer.
- ATTEMPT, checked in priority order:
  1. lock_unlock=1: go to OPEN; fail_count <= 0.
  2. lock_q==BAD_CODE, or attempt timer == ATTEMPT_TO-1: go to FAILED.
  3. Activity: clear the timer.
  4. Otherwise: increment the timer.
  - If lock_q returns to INITIAL_CODE without unlock, go to READY and leave the count unchanged.
- FAILED (exactly 1 cycle): fail_count <= fail_count+1, saturating at MAX_FAILS. If the new value == MAX_FAILS, go to LOCKOUT and clear the lockout timer; else go to WAIT_REL.
- LOCKOUT: count to LOCKOUT_CYC-1, then go to WAIT_REL with fail_count <= 0.
- OPEN: stay while lock_unlock=1. When it falls, go to WAIT_REL.
- WAIT_REL: go to READY when btn_u=0, btn_z=0 and lock_q==INITIAL_CODE.
- Simultaneous unlock and BAD/timeout in ATTEMPT: unlock wins. BAD and timeout in the same cycle: counted once.
- Timers are sized $clog2 of their limit and never wrap. The attempt timer runs only in ATTEMPT; the lockout timer runs only in LOCKOUT.

## Timing

- Reset (async): state=READY, both timers=0, fail_count=0, btn_prev=0.
  - Outputs during reset: lock_rst=0, door_open=0, locked_out=0; lock_u/lock_z pass buttons through.
  - The lock takes rst directly as well.
- Reset asserted mid-LOCKOUT or mid-OPEN: immediate return to the reset values above; no lockout persists.
- BAD seen at edge N → FAILED during cycle N+1 (lock_rst=1 for that one cycle) → fail_count updated at edge N+2.
- Lockout: lock_rst and locked_out held for exactly LOCKOUT_CYC cycles.
- Attempt timeout: FAILED entered ATTEMPT_TO cycles after the last activity.
- Unlock at edge N → door_open=1 from cycle N+1.

## Test plan

Common parameters: MAX_FAILS=3, ATTEMPT_TO=20, LOCKOUT_CYC=50, BAD_CODE=4'hA. A lock behavioural model drives lock_q and lock_unlock.

- Correct code 1-0-1-1 → OPEN, door_open=1, fail_count=0. When unlock falls with buttons released → WAIT_REL → READY.
- One wrong entry (lock_q=4'hA) → one-cycle lock_rst pulse, fail_count=1, state READY after buttons are released.
- Three consecutive BAD entries → locked_out=1 for exactly 50 cycles. lock_u/lock_z stay 0 while btn_u is held. Afterwards fail_count=0.
- Enter the first digit, then idle 20 cycles → FAILED, fail_count increments. Toggling a button every 10 cycles keeps ATTEMPT alive indefinitely.
- Two failures then a correct code → fail_count cleared to 0; a third failure afterwards gives fail_count=1, no lockout.
- Assert rst at cycle 25 of a lockout → locked_out=0 and fail_count=0 immediately; buttons pass through after rst is released.
